// File: rtl/pc_seq_if.sv
// pc_seq_if: hazard/decode <-> fetch-PC sequencer signal bundle.
// master = hazard unit + decode side (drives stall and redirect request).
// slave  = pc_sequencer (drives fetch/decode PCs and status).
interface pc_seq_if;
   logic        stall;
   logic        redir_valid;
   logic [1:0]  redir_kind;
   logic        br_taken;
   logic [15:0] br_offset;
   logic [25:0] j_index;
   logic [31:0] jr_target;
   logic [31:0] pc_f;
   logic [31:0] pc_d;
   logic [31:0] link_pc;
   logic        fetch_valid;
   logic        addr_err;

   modport master (
      output stall, redir_valid, redir_kind, br_taken, br_offset, j_index, jr_target,
      input  pc_f, pc_d, link_pc, fetch_valid, addr_err
   );

   modport slave (
      input  stall, redir_valid, redir_kind, br_taken, br_offset, j_index, jr_target,
      output pc_f, pc_d, link_pc, fetch_valid, addr_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register and next-PC sequencing for the pipelined MIPS core.
// Build option: define DELAY_SLOT_EN for MIPS delay-slot semantics (no bubble after a
// control transfer); left undefined, the instruction after a transfer is squashed
// through one FLUSH cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | normal sequencing, redirects accepted
// S_PEND  | redirect arrived during stall; target parked in r_pend_pc
// S_FLUSH | squash cycle: fetch_valid low until the next unstalled edge
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter bit          JR_ALIGN = 1'b1
) (
   input  logic     clk,
   input  logic     reset,
   pc_seq_if.slave  bus
);

   typedef enum logic [1:0] {S_RUN, S_PEND, S_FLUSH} state_t;

`ifdef DELAY_SLOT_EN
   localparam state_t S_AFTER_XFER  = S_RUN;
   localparam logic   FV_AFTER_XFER = 1'b1;
`else
   localparam state_t S_AFTER_XFER  = S_FLUSH;
   localparam logic   FV_AFTER_XFER = 1'b0;
`endif

   state_t      r_state, w_state_nx;
   logic [31:0] r_pc_f, r_pc_d, r_pend_pc;
   logic [31:0] w_pc_f_nx, w_pc_d_nx, w_pend_pc_nx;
   logic        r_fetch_valid, r_addr_err, w_fetch_valid_nx, w_addr_err_nx;
   logic [31:0] w_pc_f_plus4, w_pc_d_plus4;
   logic [31:0] w_br_target, w_j_target, w_jr_target, w_target;
   logic        w_redir, w_jr_misaligned;

   assign w_pc_f_plus4 = r_pc_f + 32'd4;
   assign w_pc_d_plus4 = r_pc_d + 32'd4;
   assign w_br_target  = w_pc_d_plus4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
   assign w_j_target   = {w_pc_d_plus4[31:28], bus.j_index, 2'b00};
   assign w_jr_target  = JR_ALIGN ? {bus.jr_target[31:2], 2'b00} : bus.jr_target;

   // Misalignment only matters when this jr actually redirects fetch.
   assign w_jr_misaligned = JR_ALIGN && (bus.redir_kind == 2'b10) && (bus.jr_target[1:0] != 2'b00);

   // Kind 11 is reserved and falls through as "no redirect".
   assign w_redir = bus.redir_valid &&
                    ((bus.redir_kind == 2'b01) || (bus.redir_kind == 2'b10) ||
                     ((bus.redir_kind == 2'b00) && bus.br_taken));

   // Redirect target select.
   always_comb begin
      w_target = w_pc_f_plus4;
      case (bus.redir_kind)
         2'b00:   w_target = w_br_target;
         2'b01:   w_target = w_j_target;
         2'b10:   w_target = w_jr_target;
         default: w_target = w_pc_f_plus4;
      endcase
   end

   // Next-state and next-register values; everything holds unless a case advances it.
   always_comb begin
      w_state_nx       = r_state;
      w_pc_f_nx        = r_pc_f;
      w_pc_d_nx        = r_pc_d;
      w_pend_pc_nx     = r_pend_pc;
      w_fetch_valid_nx = r_fetch_valid;
      w_addr_err_nx    = r_addr_err;
      case (r_state)
         S_RUN: begin
            if (w_redir && w_jr_misaligned) w_addr_err_nx = 1'b1;
            if (!bus.stall) begin
               w_pc_d_nx = r_pc_f;
               if (w_redir) begin
                  w_pc_f_nx        = w_target;
                  w_state_nx       = S_AFTER_XFER;
                  w_fetch_valid_nx = FV_AFTER_XFER;
               end else begin
                  w_pc_f_nx        = w_pc_f_plus4;
                  w_fetch_valid_nx = 1'b1;
               end
            end else if (w_redir) begin
               w_pend_pc_nx = w_target;
               w_state_nx   = S_PEND;
            end
         end
         // Decode is frozen here, so further redirect pulses are ignored.
         S_PEND: begin
            if (!bus.stall) begin
               w_pc_d_nx        = r_pc_f;
               w_pc_f_nx        = r_pend_pc;
               w_state_nx       = S_AFTER_XFER;
               w_fetch_valid_nx = FV_AFTER_XFER;
            end
         end
         // The squashed instruction is in decode, so its redirect requests are ignored.
         S_FLUSH: begin
            if (!bus.stall) begin
               w_pc_d_nx        = r_pc_f;
               w_pc_f_nx        = w_pc_f_plus4;
               w_fetch_valid_nx = 1'b1;
               w_state_nx       = S_RUN;
            end
         end
         default: w_state_nx = S_RUN;
      endcase
   end

   // State and PC registers; reset discards any parked redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_RUN;
         r_pc_f        <= RESET_PC;
         r_pc_d        <= RESET_PC - 32'd4;
         r_pend_pc     <= RESET_PC;
         r_fetch_valid <= 1'b0;
         r_addr_err    <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_pc_f        <= w_pc_f_nx;
         r_pc_d        <= w_pc_d_nx;
         r_pend_pc     <= w_pend_pc_nx;
         r_fetch_valid <= w_fetch_valid_nx;
         r_addr_err    <= w_addr_err_nx;
      end
   end

   assign bus.pc_f        = r_pc_f;
   assign bus.pc_d        = r_pc_d;
   assign bus.link_pc     = r_pc_d + 32'd8;
   assign bus.fetch_valid = r_fetch_valid;
   assign bus.addr_err    = r_addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer in either DELAY_SLOT_EN build.
module tb_pc_sequencer;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   pc_seq_if bus_if ();

   pc_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

`ifdef DELAY_SLOT_EN
   localparam logic FV_XFER  = 1'b1;
   localparam int   ZEROS_EXP = 0;
`else
   localparam logic FV_XFER  = 1'b0;
   localparam int   ZEROS_EXP = 1;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs;
      bus_if.stall       = 1'b0;
      bus_if.redir_valid = 1'b0;
      bus_if.redir_kind  = 2'b00;
      bus_if.br_taken    = 1'b0;
      bus_if.br_offset   = 16'h0000;
      bus_if.j_index     = 26'h0;
      bus_if.jr_target   = 32'h0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      clear_inputs();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      @(posedge clk);
      #1;
      clear_inputs();
      reset = 1'b1;
      #2;
      n_tests++; if (bus_if.pc_f !== 32'h3000) begin n_fail++; $display("FAIL reset_pc_f got %h exp %h", bus_if.pc_f, 32'h3000); end
      n_tests++; if (bus_if.pc_d !== 32'h2FFC) begin n_fail++; $display("FAIL reset_pc_d got %h exp %h", bus_if.pc_d, 32'h2FFC); end
      n_tests++; if (bus_if.link_pc !== 32'h3004) begin n_fail++; $display("FAIL reset_link got %h exp %h", bus_if.link_pc, 32'h3004); end
      n_tests++; if (bus_if.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b exp 0", bus_if.fetch_valid); end
      n_tests++; if (bus_if.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b exp 0", bus_if.addr_err); end
      #2;
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step(1);
         n_tests++; if (bus_if.pc_f !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc_f[%0d] got %h exp %h", i, bus_if.pc_f, 32'h3000 + 32'(4 * i)); end
         n_tests++; if (bus_if.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv[%0d] got %b exp 1", i, bus_if.fetch_valid); end
      end
   endtask

   task automatic test_branch;
      do_reset();
      step(5);
      n_tests++; if (bus_if.pc_d !== 32'h3010) begin n_fail++; $display("FAIL br_setup_pc_d got %h exp %h", bus_if.pc_d, 32'h3010); end
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b00; bus_if.br_taken = 1'b1; bus_if.br_offset = 16'hFFFC;
      step(1);
      clear_inputs();
      n_tests++; if (bus_if.pc_f !== 32'h3004) begin n_fail++; $display("FAIL br_taken_pc_f got %h exp %h", bus_if.pc_f, 32'h3004); end
      n_tests++; if (bus_if.pc_d !== 32'h3014) begin n_fail++; $display("FAIL br_taken_pc_d got %h exp %h", bus_if.pc_d, 32'h3014); end
      n_tests++; if (bus_if.fetch_valid !== FV_XFER) begin n_fail++; $display("FAIL br_taken_fv got %b exp %b", bus_if.fetch_valid, FV_XFER); end
      step(1);
      n_tests++; if (bus_if.pc_f !== 32'h3008) begin n_fail++; $display("FAIL br_after_pc_f got %h exp %h", bus_if.pc_f, 32'h3008); end
      n_tests++; if (bus_if.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL br_after_fv got %b exp 1", bus_if.fetch_valid); end

      do_reset();
      step(5);
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b00; bus_if.br_taken = 1'b0; bus_if.br_offset = 16'hFFFC;
      step(1);
      clear_inputs();
      n_tests++; if (bus_if.pc_f !== 32'h3018) begin n_fail++; $display("FAIL br_not_taken_pc_f got %h exp %h", bus_if.pc_f, 32'h3018); end
      n_tests++; if (bus_if.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL br_not_taken_fv got %b exp 1", bus_if.fetch_valid); end

      do_reset();
      step(5);
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b00; bus_if.br_taken = 1'b1; bus_if.br_offset = 16'h7FFF;
      step(1);
      clear_inputs();
      n_tests++; if (bus_if.pc_f !== 32'h0002_3010) begin n_fail++; $display("FAIL br_max_off_pc_f got %h exp %h", bus_if.pc_f, 32'h0002_3010); end
      n_tests++; if (bus_if.addr_err !== 1'b0) begin n_fail++; $display("FAIL br_max_off_addr_err got %b exp 0", bus_if.addr_err); end
   endtask

   task automatic test_reserved_kind;
      do_reset();
      step(5);
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b11; bus_if.jr_target = 32'h0000_4000; bus_if.br_taken = 1'b1;
      step(1);
      clear_inputs();
      n_tests++; if (bus_if.pc_f !== 32'h3018) begin n_fail++; $display("FAIL reserved_kind_pc_f got %h exp %h", bus_if.pc_f, 32'h3018); end
   endtask

   task automatic test_jump;
      do_reset();
      step(9);
      n_tests++; if (bus_if.link_pc !== 32'h3028) begin n_fail++; $display("FAIL j_link got %h exp %h", bus_if.link_pc, 32'h3028); end
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b01; bus_if.j_index = 26'h0000C10;
      step(1);
      clear_inputs();
      n_tests++; if (bus_if.pc_f !== 32'h0000_3040) begin n_fail++; $display("FAIL j_pc_f got %h exp %h", bus_if.pc_f, 32'h3040); end
   endtask

   task automatic test_stall_redirect;
      do_reset();
      step(5);
      bus_if.stall = 1'b1;
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b10; bus_if.jr_target = 32'h0000_3100;
      step(1);
      bus_if.redir_valid = 1'b0;
      n_tests++; if (bus_if.pc_f !== 32'h3014) begin n_fail++; $display("FAIL stall_hold1_pc_f got %h exp %h", bus_if.pc_f, 32'h3014); end
      step(1);
      n_tests++; if (bus_if.pc_f !== 32'h3014) begin n_fail++; $display("FAIL stall_hold2_pc_f got %h exp %h", bus_if.pc_f, 32'h3014); end
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b10; bus_if.jr_target = 32'h0000_3200;
      step(1);
      bus_if.redir_valid = 1'b0;
      n_tests++; if (bus_if.pc_f !== 32'h3014) begin n_fail++; $display("FAIL stall_hold3_pc_f got %h exp %h", bus_if.pc_f, 32'h3014); end
      n_tests++; if (bus_if.pc_d !== 32'h3010) begin n_fail++; $display("FAIL stall_hold3_pc_d got %h exp %h", bus_if.pc_d, 32'h3010); end
      bus_if.stall = 1'b0;
      step(1);
      n_tests++; if (bus_if.pc_f !== 32'h3100) begin n_fail++; $display("FAIL stall_release_pc_f got %h exp %h", bus_if.pc_f, 32'h3100); end
      n_tests++; if (bus_if.pc_d !== 32'h3014) begin n_fail++; $display("FAIL stall_release_pc_d got %h exp %h", bus_if.pc_d, 32'h3014); end
      n_tests++; if (bus_if.fetch_valid !== FV_XFER) begin n_fail++; $display("FAIL stall_release_fv got %b exp %b", bus_if.fetch_valid, FV_XFER); end
      step(1);
      n_tests++; if (bus_if.pc_f !== 32'h3104) begin n_fail++; $display("FAIL stall_after_pc_f got %h exp %h", bus_if.pc_f, 32'h3104); end
      clear_inputs();
   endtask

   task automatic test_jr_align;
      do_reset();
      step(2);
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b10; bus_if.jr_target = 32'h0000_3103;
      step(1);
      clear_inputs();
      n_tests++; if (bus_if.pc_f !== 32'h3100) begin n_fail++; $display("FAIL jr_align_pc_f got %h exp %h", bus_if.pc_f, 32'h3100); end
      n_tests++; if (bus_if.addr_err !== 1'b1) begin n_fail++; $display("FAIL jr_align_addr_err got %b exp 1", bus_if.addr_err); end
      step(3);
      n_tests++; if (bus_if.pc_f !== 32'h310C) begin n_fail++; $display("FAIL jr_after_pc_f got %h exp %h", bus_if.pc_f, 32'h310C); end
      n_tests++; if (bus_if.addr_err !== 1'b1) begin n_fail++; $display("FAIL jr_sticky_addr_err got %b exp 1", bus_if.addr_err); end
      bus_if.stall = 1'b1;
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b10; bus_if.jr_target = 32'h0000_3200;
      step(1);
      bus_if.redir_valid = 1'b0;
      n_tests++; if (bus_if.pc_f !== 32'h310C) begin n_fail++; $display("FAIL pend_hold_pc_f got %h exp %h", bus_if.pc_f, 32'h310C); end
      reset = 1'b1;
      #1;
      n_tests++; if (bus_if.pc_f !== 32'h3000) begin n_fail++; $display("FAIL pend_reset_pc_f got %h exp %h", bus_if.pc_f, 32'h3000); end
      n_tests++; if (bus_if.addr_err !== 1'b0) begin n_fail++; $display("FAIL pend_reset_addr_err got %b exp 0", bus_if.addr_err); end
      #2;
      clear_inputs();
      reset = 1'b0;
      step(1);
      n_tests++; if (bus_if.pc_f !== 32'h3004) begin n_fail++; $display("FAIL post_reset_pc_f got %h exp %h", bus_if.pc_f, 32'h3004); end
   endtask

   task automatic test_flush_count;
      int zeros;
      do_reset();
      step(5);
      zeros = 0;
      bus_if.redir_valid = 1'b1; bus_if.redir_kind = 2'b00; bus_if.br_taken = 1'b1; bus_if.br_offset = 16'h0010;
      for (int i = 0; i < 5; i++) begin
         step(1);
         clear_inputs();
         if (bus_if.fetch_valid == 1'b0) zeros++;
      end
      n_tests++; if (zeros !== ZEROS_EXP) begin n_fail++; $display("FAIL flush_count got %0d exp %0d", zeros, ZEROS_EXP); end
      n_tests++; if (bus_if.pc_f !== 32'h3064) begin n_fail++; $display("FAIL flush_end_pc_f got %h exp %h", bus_if.pc_f, 32'h3064); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      clear_inputs();
      test_reset();
      test_branch();
      test_reserved_kind();
      test_jump();
      test_stall_redirect();
      test_jr_align();
      test_flush_count();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
